// File: rtl/dct_da_pkg.sv
// ---------------------------------------------------------------------------
// dct_da_pkg
// Shared constants and types for the DCT distributed-arithmetic engines.
//   ROM_W      : coefficient ROM data width (unsigned Q3.14)
//   FRAC_W     : fractional bits carried by ROM data and accumulator
//   ADDR_W     : ROM bit-slice address width (one bit per input sample)
//   ROUND_HALF : 2^(FRAC_W-1), bias used by the optional rounding stage
//   state_t    : engine FSM states
// ---------------------------------------------------------------------------
package dct_da_pkg;

    localparam int unsigned ROM_W      = 17;
    localparam int unsigned FRAC_W     = 14;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned ROUND_HALF = 1 << (FRAC_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : dct_da_pkg

// File: rtl/da_accum_z0.sv
// ---------------------------------------------------------------------------
// da_accum_z0
// Distributed-arithmetic engine for the DCT Z0 coefficient path. Walks the
// bits of four signed samples MSB-first, addressing an external Z0 ROM with
// each bit slice and shift-accumulating the returned Q3.14 words. The sign
// bit slice is subtracted (two's-complement weight).
//
// Ports:
//   clk        in   clock, posedge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   sample set valid
//   in_ready   out  engine idle, can accept a set
//   x_in       in   {x3,x2,x1,x0}, each IN_W-bit signed, x0 in the LSBs
//   rom_cs     out  ROM chip select (high only while running)
//   rom_addr   out  {x3[b],x2[b],x1[b],x0[b]} for current bit b
//   rom_data   in   combinational ROM word for rom_addr (unsigned Q3.14)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts result
//   y_out      out  signed result, Q(ACC_W-14).14
//
// Build option:
//   DA_ROUND_EN  when defined, y_out is rounded half toward +inf to an
//                integer (fraction bits cleared) on the way into DONE.
// ---------------------------------------------------------------------------
module da_accum_z0 #(
    parameter int IN_W  = 8,
    parameter int ROM_W = dct_da_pkg::ROM_W,
    parameter int ACC_W = ROM_W + IN_W + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [4*IN_W-1:0]              x_in,
    output logic                           rom_cs,
    output logic [dct_da_pkg::ADDR_W-1:0]  rom_addr,
    input  logic [ROM_W-1:0]               rom_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_W-1:0]        y_out
);
    import dct_da_pkg::*;

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(IN_W - 1);

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [IN_W-1:0]          r_x0, r_x1, r_x2, r_x3;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_y;
    logic                     r_out_valid;

    logic signed [ACC_W-1:0]  w_rom_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_y_next;
    logic                     w_accept;
    logic                     w_running;

    assign w_running = (r_state == RUN);
    assign w_accept  = (r_state == IDLE) && in_valid;

    assign in_ready  = (r_state == IDLE);
    assign rom_cs    = w_running;
    // Shift regs move left each RUN cycle, so their MSBs always hold bit r_cnt.
    assign rom_addr  = w_running ? {r_x3[IN_W-1], r_x2[IN_W-1], r_x1[IN_W-1], r_x0[IN_W-1]}
                                 : '0;
    assign out_valid = r_out_valid;
    assign y_out     = r_y;

    // ROM words are unsigned: zero-extend into the signed accumulator domain.
    assign w_rom_ext = signed'({{(ACC_W-ROM_W){1'b0}}, rom_data});

    always_comb begin
        w_acc_next = r_acc;
        if (r_cnt == CNT_TOP) begin
            // Sign bit slice carries weight -2^(IN_W-1).
            w_acc_next = -w_rom_ext;
        end else begin
            w_acc_next = (r_acc <<< 1) + w_rom_ext;
        end
    end

`ifdef DA_ROUND_EN
    logic signed [ACC_W-1:0] w_biased;
    assign w_biased = w_acc_next + signed'(ACC_W'(ROUND_HALF));
    // Arithmetic shift right then left by FRAC_W == clearing the fraction bits.
    assign w_y_next = {w_biased[ACC_W-1:FRAC_W], {FRAC_W{1'b0}}};
`else
    assign w_y_next = w_acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x0    <= x_in[0*IN_W +: IN_W];
                        r_x1    <= x_in[1*IN_W +: IN_W];
                        r_x2    <= x_in[2*IN_W +: IN_W];
                        r_x3    <= x_in[3*IN_W +: IN_W];
                        r_cnt   <= CNT_TOP;
                        r_acc   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_x0  <= r_x0 << 1;
                    r_x1  <= r_x1 << 1;
                    r_x2  <= r_x2 << 1;
                    r_x3  <= r_x3 << 1;
                    if (r_cnt == '0) begin
                        r_y         <= w_y_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : da_accum_z0

// File: tb/tb_da_accum_z0.sv
// ---------------------------------------------------------------------------
// tb_da_accum_z0
// Directed bench for da_accum_z0 with a behavioural Z0 ROM whose word for
// address a is popcount(a) * 0x2D41 (c4), so 1111 returns 0xB504 (4c4).
// ---------------------------------------------------------------------------
module tb_da_accum_z0;

    localparam int IN_W  = 8;
    localparam int ROM_W = 17;
    localparam int ACC_W = ROM_W + IN_W + 1;
    localparam int C4    = 11585;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [4*IN_W-1:0]       x_in;
    logic                    rom_cs;
    logic [3:0]              rom_addr;
    logic [ROM_W-1:0]        rom_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] y_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_data = ROM_W'(C4 * $countones(rom_addr));

    da_accum_z0 #(.IN_W(IN_W), .ROM_W(ROM_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out)
    );

    typedef struct {
        string        name;
        logic [31:0]  x;
        longint       y_full;
        longint       y_rnd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint pick(input vec_t v);
`ifdef DA_ROUND_EN
        return v.y_rnd;
`else
        return v.y_full;
`endif
    endfunction

    // Called at a negedge; presents x and returns #1 after the accept edge.
    task automatic send(input logic [31:0] x);
        int waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", longint'(in_ready), 1);
        in_valid = 1'b1;
        x_in     = x;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Checks the eight RUN cycles and the DONE entry; ends at a negedge in DONE.
    task automatic expect_run(input string name, input logic [31:0] x, input longint y_exp);
        logic [31:0] xv;
        logic [3:0]  a;
        xv = x;
        for (int b = IN_W - 1; b >= 0; b--) begin
            @(negedge clk);
            a = {xv[24+b], xv[16+b], xv[8+b], xv[b]};
            // {out_valid, rom_cs, in_ready, rom_addr}
            chk({name, "_run"}, longint'({out_valid, rom_cs, in_ready, rom_addr}),
                longint'({1'b0, 1'b1, 1'b0, a}));
        end
        @(negedge clk);
        chk({name, "_done_flags"}, longint'({out_valid, rom_cs, in_ready, rom_addr}), 64'h40);
        chk({name, "_y"}, longint'(y_out), y_exp);
    endtask

    // Handshake out of DONE from a negedge; ends at the following negedge in IDLE.
    task automatic drain(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_idle"}, longint'({out_valid, in_ready, rom_cs}), longint'(3'b010));
    endtask

    initial begin
        logic [31:0] x_new;
        longint      y_hold;
        int          bad;

        vecs.push_back('{"ones",   32'h01010101,   46340,    49152});
        vecs.push_back('{"x0neg1", 32'h000000FF,  -11585,   -16384});
        vecs.push_back('{"min",    32'h80808080, -5931520, -5931008});
        vecs.push_back('{"max",    32'h7F7F7F7F,  5885180,  5881856});
        vecs.push_back('{"mixed",  32'h0005FE03,    69510,    65536});
        vecs.push_back('{"mixed2", 32'h9CF9140A,  -892045,  -884736});
        vecs.push_back('{"zero",   32'h00000000,        0,        0});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;

        // In reset
        #12;
        chk("rst_flags", longint'({in_ready, rom_cs, out_valid, rom_addr}), longint'(7'b1000000));
        chk("rst_y", longint'(y_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no input
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({in_ready, rom_cs, out_valid} !== 3'b100) bad++;
        end
        chk("idle_quiet", longint'(bad), 0);

        // Reset asserted mid-RUN
        send(32'h01010101);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrun_rst", longint'({in_ready, rom_cs, out_valid, rom_addr}), longint'(7'b1000000));
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        chk("midrun_no_out", longint'(bad), 0);

        // Table-driven sets
        foreach (vecs[i]) begin
            send(vecs[i].x);
            expect_run(vecs[i].name, vecs[i].x, pick(vecs[i]));
            drain(vecs[i].name);
        end

        // Reset asserted mid-DONE discards the pending result
        send(32'h7F7F7F7F);
        expect_run("pre_done_rst", 32'h7F7F7F7F, pick(vecs[3]));
        #2 rst_n = 1'b0;
        #1 chk("middone_rst", longint'({out_valid, in_ready}), longint'(2'b01));
        chk("middone_y", longint'(y_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure: result held, new set waits for the handshake
        send(vecs[1].x);
        expect_run("bp", vecs[1].x, pick(vecs[1]));
        y_hold   = pick(vecs[1]);
        x_new    = vecs[4].x;
        in_valid = 1'b1;
        x_in     = x_new;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({out_valid, in_ready, rom_cs} !== 3'b100) bad++;
            if (longint'(y_out) != y_hold) bad++;
        end
        chk("bp_hold", longint'(bad), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle", longint'({out_valid, in_ready, rom_cs}), longint'(3'b010));
        @(posedge clk);
        #1 in_valid = 1'b0;
        expect_run("bp_next", x_new, pick(vecs[4]));
        drain("bp_next");

        // out_ready while idle has no effect
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_idle", longint'({out_valid, in_ready, rom_cs}), longint'(3'b010));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_da_accum_z0
